// File: rtl/reaction_stimulus.sv
// Reaction-timer trial controller: random pre-stimulus delay, LED, press capture.
// Define REACTION_BEST_TIME_EN to build the best-time register; otherwise BestBcd is 8'h99.

module reaction_stimulus #(
  parameter int         MIN_DELAY_TICKS = 100,
  parameter logic [7:0] LFSR_SEED       = 8'h01
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Tick,
  input  logic       Startn,
  input  logic       Pushn,
  input  logic [7:0] BcdIn,
  output logic       LEDn,
  output logic       CountEn,
  output logic       CountClr,
  output logic       FalseStart,
  output logic       Timeout,
  output logic [7:0] BestBcd
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FOUL  = 3'd4;

  localparam logic [8:0] MIN_DELAY_C = 9'(MIN_DELAY_TICKS);
  localparam logic [7:0] BCD_MAX_C   = 8'h99;

  // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Moore output decode, packed as {LEDn, CountEn, CountClr, FalseStart}.
  function automatic logic [3:0] decode_outputs(input logic [2:0] st);
    logic [3:0] o;
    case (st)
      ST_IDLE:  o = 4'b1010;
      ST_WAIT:  o = 4'b1010;
      ST_ARMED: o = 4'b0100;
      ST_DONE:  o = 4'b1000;
      ST_FOUL:  o = 4'b1011;
      default:  o = 4'b1010;
    endcase
    return o;
  endfunction

  logic       start_meta_r, start_sync_r, start_prev_r, start_press_r;
  logic       push_meta_r, push_sync_r, push_prev_r, push_press_r;
  logic [7:0] lfsr_r;
  logic [8:0] delay_r;
  logic [2:0] state_r;
  logic [2:0] state_next_s;
  logic [3:0] outs_r;
  logic       timeout_r;
  logic       delay_expire_s;
  logic       count_full_s;

  // Two-FF synchronizers plus a registered falling-edge detector per button.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      start_meta_r  <= 1'b1;
      start_sync_r  <= 1'b1;
      start_prev_r  <= 1'b1;
      start_press_r <= 1'b0;
      push_meta_r   <= 1'b1;
      push_sync_r   <= 1'b1;
      push_prev_r   <= 1'b1;
      push_press_r  <= 1'b0;
    end else begin
      start_meta_r  <= Startn;
      start_sync_r  <= start_meta_r;
      start_prev_r  <= start_sync_r;
      start_press_r <= start_prev_r & ~start_sync_r;
      push_meta_r   <= Pushn;
      push_sync_r   <= push_meta_r;
      push_prev_r   <= push_sync_r;
      push_press_r  <= push_prev_r & ~push_sync_r;
    end
  end

  // Free-running random source for the pre-stimulus delay.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign delay_expire_s = Tick && (delay_r == 9'd1);
  assign count_full_s   = Tick && (BcdIn == BCD_MAX_C);

  // Trial sequencing; a push always wins over a simultaneous tick event.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_press_r) state_next_s = ST_WAIT;
        else               state_next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (push_press_r)        state_next_s = ST_FOUL;
        else if (delay_expire_s) state_next_s = ST_ARMED;
        else                     state_next_s = ST_WAIT;
      end
      ST_ARMED: begin
        if (push_press_r)      state_next_s = ST_DONE;
        else if (count_full_s) state_next_s = ST_DONE;
        else                   state_next_s = ST_ARMED;
      end
      ST_DONE: begin
        if (start_press_r) state_next_s = ST_WAIT;
        else               state_next_s = ST_DONE;
      end
      ST_FOUL: begin
        if (start_press_r) state_next_s = ST_WAIT;
        else               state_next_s = ST_FOUL;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, delay counter, timeout flag and registered Moore outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r   <= ST_IDLE;
      delay_r   <= 9'd0;
      outs_r    <= 4'b1010;
      timeout_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      outs_r  <= decode_outputs(state_next_s);
      if ((state_next_s == ST_WAIT) && (state_r != ST_WAIT)) begin
        delay_r <= MIN_DELAY_C + {1'b0, lfsr_r};
      end else if ((state_r == ST_WAIT) && Tick) begin
        delay_r <= delay_r - 9'd1;
      end else begin
        delay_r <= delay_r;
      end
      if ((state_r == ST_ARMED) && (state_next_s == ST_DONE)) begin
        timeout_r <= ~push_press_r;
      end else if (state_next_s != ST_DONE) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign LEDn       = outs_r[3];
  assign CountEn    = outs_r[2];
  assign CountClr   = outs_r[1];
  assign FalseStart = outs_r[0];
  assign Timeout    = timeout_r;

`ifdef REACTION_BEST_TIME_EN
  logic       done_entry_r;
  logic [7:0] best_r;

  // Capture the count in the first DONE cycle of a non-timeout trial.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      done_entry_r <= 1'b0;
      best_r       <= BCD_MAX_C;
    end else begin
      done_entry_r <= (state_r == ST_ARMED) && (state_next_s == ST_DONE);
      if (done_entry_r && (state_r == ST_DONE) && !timeout_r && (BcdIn < best_r)) begin
        best_r <= BcdIn;
      end else begin
        best_r <= best_r;
      end
    end
  end

  assign BestBcd = best_r;
`else
  assign BestBcd = BCD_MAX_C;
`endif

endmodule

// File: tb/tb_reaction_stimulus.sv
// Directed bench for reaction_stimulus with a behavioural two-digit BCD counter.

module tb_reaction_stimulus;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Tick = 1'b0;
  logic       Startn = 1'b1;
  logic       Pushn = 1'b1;
  logic [7:0] BcdIn;
  logic       LEDn, CountEn, CountClr, FalseStart, Timeout;
  logic [7:0] BestBcd;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] m_lfsr;
  logic [7:0] exp_best;

  reaction_stimulus #(.MIN_DELAY_TICKS(100), .LFSR_SEED(8'h01)) dut (
    .Clock(Clock), .Resetn(Resetn), .Tick(Tick), .Startn(Startn), .Pushn(Pushn),
    .BcdIn(BcdIn), .LEDn(LEDn), .CountEn(CountEn), .CountClr(CountClr),
    .FalseStart(FalseStart), .Timeout(Timeout), .BestBcd(BestBcd)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) return 8'h00;
      else return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // External BCD counter driven by the controller's enable/clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) BcdIn <= 8'h00;
    else if (CountClr) BcdIn <= 8'h00;
    else if (CountEn && Tick) BcdIn <= bcd_inc(BcdIn);
    else BcdIn <= BcdIn;
  end

  // Reference LFSR used to time the first Start press.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) m_lfsr <= 8'h01;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t);
    Tick = t;
    @(posedge Clock);
    #1;
    Tick = 1'b0;
  endtask

  task automatic tick();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start();
    Startn = 1'b0;
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    Startn = 1'b1;
  endtask

  task automatic press_push(input logic tick_at_detect);
    Pushn = 1'b0;
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(tick_at_detect);
    Pushn = 1'b1;
  endtask

  task automatic settle();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b0);
  endtask

  task automatic wait_armed(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (LEDn == 1'b0) got = 1'b1;
    end
    chk(tag, {15'd0, got}, 16'd1);
  endtask

  task automatic run_trial(input int n, input logic tick_at_detect, input logic [7:0] exp_bcd,
                           input logic [7:0] exp_b, input string tag);
    press_start();
    settle();
    wait_armed({tag, "_armed"});
    ticks(n);
    press_push(tick_at_detect);
    chk({tag, "_counten"}, {15'd0, CountEn}, 16'd0);
    settle();
    chk({tag, "_bcd"}, {8'd0, BcdIn}, {8'd0, exp_bcd});
    chk({tag, "_timeout"}, {15'd0, Timeout}, 16'd0);
    chk({tag, "_best"}, {8'd0, BestBcd}, {8'd0, exp_b});
  endtask

  initial begin
    // Reset state
    cyc(1'b0); cyc(1'b0);
    chk("rst_ledn", {15'd0, LEDn}, 16'd1);
    chk("rst_countclr", {15'd0, CountClr}, 16'd1);
    chk("rst_counten", {15'd0, CountEn}, 16'd0);
    chk("rst_falsestart", {15'd0, FalseStart}, 16'd0);
    chk("rst_timeout", {15'd0, Timeout}, 16'd0);
    chk("rst_best", {8'd0, BestBcd}, 16'h0099);
    Resetn = 1'b1;
    cyc(1'b0);

    // Push in IDLE is ignored
    press_push(1'b0);
    settle();
    chk("idle_push_ledn", {15'd0, LEDn}, 16'd1);
    chk("idle_push_clr", {15'd0, CountClr}, 16'd1);
    chk("idle_push_en", {15'd0, CountEn}, 16'd0);
    chk("idle_push_foul", {15'd0, FalseStart}, 16'd0);

    // Time the Start press so the LFSR reads 8'h20 when WAIT is entered
    for (int i = 0; i < 300; i++) begin
      if (lfsr_step(lfsr_step(lfsr_step(m_lfsr))) == 8'h20) break;
      cyc(1'b0);
    end
    chk("lfsr_aligned", {8'd0, lfsr_step(lfsr_step(lfsr_step(m_lfsr)))}, 16'h0020);
    press_start();
    ticks(131);
    chk("wait131_ledn", {15'd0, LEDn}, 16'd1);
    chk("wait131_clr", {15'd0, CountClr}, 16'd1);
    tick();
    chk("wait132_ledn", {15'd0, LEDn}, 16'd0);
    chk("wait132_en", {15'd0, CountEn}, 16'd1);
    chk("wait132_clr", {15'd0, CountClr}, 16'd0);
    ticks(23);
    chk("armed23_bcd", {8'd0, BcdIn}, 16'h0023);
    press_push(1'b0);
    chk("done_en", {15'd0, CountEn}, 16'd0);
    chk("done_ledn", {15'd0, LEDn}, 16'd1);
    chk("done_timeout", {15'd0, Timeout}, 16'd0);
    ticks(2);
    chk("done_hold_bcd", {8'd0, BcdIn}, 16'h0023);
`ifdef REACTION_BEST_TIME_EN
    exp_best = 8'h23;
`else
    exp_best = 8'h99;
`endif
    chk("done_best", {8'd0, BestBcd}, {8'd0, exp_best});

    // False start 50 ticks into WAIT
    press_start();
    chk("restart_clr", {15'd0, CountClr}, 16'd1);
    settle();
    ticks(50);
    press_push(1'b0);
    chk("foul_flag", {15'd0, FalseStart}, 16'd1);
    chk("foul_ledn", {15'd0, LEDn}, 16'd1);
    chk("foul_clr", {15'd0, CountClr}, 16'd1);
    chk("foul_en", {15'd0, CountEn}, 16'd0);
    settle();
    press_start();
    chk("foul_exit_flag", {15'd0, FalseStart}, 16'd0);
    chk("foul_exit_clr", {15'd0, CountClr}, 16'd1);
    settle();

    // Timeout when the count reaches 99
    wait_armed("to_armed");
    ticks(99);
    chk("to_99_bcd", {8'd0, BcdIn}, 16'h0099);
    chk("to_99_en", {15'd0, CountEn}, 16'd1);
    chk("to_99_timeout", {15'd0, Timeout}, 16'd0);
    tick();
    chk("to_timeout", {15'd0, Timeout}, 16'd1);
    chk("to_en", {15'd0, CountEn}, 16'd0);
    chk("to_ledn", {15'd0, LEDn}, 16'd1);
    settle();
    chk("to_best", {8'd0, BestBcd}, {8'd0, exp_best});
    press_start();
    chk("to_cleared", {15'd0, Timeout}, 16'd0);
    settle();

    // Asynchronous reset while ARMED
    wait_armed("rst_armed");
    ticks(5);
    chk("pre_rst_ledn", {15'd0, LEDn}, 16'd0);
    Resetn = 1'b0;
    #1;
    chk("async_ledn", {15'd0, LEDn}, 16'd1);
    chk("async_en", {15'd0, CountEn}, 16'd0);
    chk("async_clr", {15'd0, CountClr}, 16'd1);
    chk("async_best", {8'd0, BestBcd}, 16'h0099);
    cyc(1'b0); cyc(1'b0);
    Resetn = 1'b1;
    cyc(1'b0);
    press_push(1'b0);
    settle();
    chk("post_rst_push_ledn", {15'd0, LEDn}, 16'd1);
    chk("post_rst_push_foul", {15'd0, FalseStart}, 16'd0);

    // Best-time sequence; the last push has a Tick in its detection cycle
`ifdef REACTION_BEST_TIME_EN
    run_trial(42, 1'b0, 8'h42, 8'h42, "best1");
    run_trial(57, 1'b0, 8'h57, 8'h42, "best2");
    run_trial(30, 1'b1, 8'h31, 8'h31, "best3");
`else
    run_trial(42, 1'b0, 8'h42, 8'h99, "best1");
    run_trial(57, 1'b0, 8'h57, 8'h99, "best2");
    run_trial(30, 1'b1, 8'h31, 8'h99, "best3");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
